fp_mul_issue: RTL and testbench

//  Front/back stage wrapped around the iterative FP32 multiplier core.
//  - Accepts operand requests from the ALU; resolves IEEE special cases (NaN/inf/zero) locally.
//  - Launches the core only for finite normal operands.
//  - Consumes the core's raw product: rebiases the exponent, applies overflow/underflow, returns one result.

---
 rtl/fp_mul_issue_if.sv | 28 ++
 rtl/fp_mul_issue.sv | 136 +++++++++++++
 tb/tb_fp_mul_issue.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_issue_if.sv
// Request, core-launch and response signals that connect the FP32 multiply
// issue stage to the ALU and to the iterative multiplier core.
interface fp_mul_issue_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_core_valid;
  logic [31:0] o_core_a;
  logic [31:0] o_core_b;
  logic        i_core_valid;
  logic [31:0] i_core_result;
  logic        o_resp_valid;
  logic [31:0] o_result;
  logic [3:0]  o_flags;

  modport slave (
    input  i_req_valid, i_a, i_b, i_core_valid, i_core_result,
    output o_req_ready, o_core_valid, o_core_a, o_core_b,
           o_resp_valid, o_result, o_flags
  );

  modport master (
    output i_req_valid, i_a, i_b, i_core_valid, i_core_result,
    input  o_req_ready, o_core_valid, o_core_a, o_core_b,
           o_resp_valid, o_result, o_flags
  );
endinterface

// File: rtl/fp_mul_issue.sv
// FP32 multiply issue stage: resolves IEEE special operands locally, launches the
// iterative core for finite normals, then rebiases and saturates the raw product.
module fp_mul_issue #(
  parameter int CORE_TIMEOUT = 31
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  fp_mul_issue_if.slave  bus
);
  localparam int CW = $clog2(CORE_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       count_reg;
  logic signed [9:0]   e_base_reg;
  logic [7:0]          s8_reg;
  logic                sign_reg;
  logic                core_valid_q;

  logic [7:0]  a_exp, b_exp;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        accept, special, invalid, sign_in;
  logic [31:0] special_result;
  logic        complete, timeout, carry;
  logic signed [9:0] e_final;
  logic        overflow, underflow;

  assign a_exp  = bus.i_a[30:23];
  assign b_exp  = bus.i_b[30:23];
  assign a_nan  = (a_exp == 8'hFF) && (bus.i_a[22:0] != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (bus.i_b[22:0] != 23'd0);
  assign a_inf  = (a_exp == 8'hFF) && (bus.i_a[22:0] == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (bus.i_b[22:0] == 23'd0);
  // Denormals have a zero exponent and are treated as zero.
  assign a_zero = (a_exp == 8'h00);
  assign b_zero = (b_exp == 8'h00);

  assign accept  = bus.i_req_valid && (state_reg == IDLE);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  assign invalid = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
  assign sign_in = bus.i_a[31] ^ bus.i_b[31];

  always_comb begin
    special_result = {sign_in, 31'd0};
    if (invalid)
      special_result = 32'h7FC0_0000;
    else if (a_inf || b_inf)
      special_result = {sign_in, 8'hFF, 23'd0};
  end

  // A level left high by the previous op must not count as a new completion.
  assign complete  = bus.i_core_valid && !core_valid_q;
  assign timeout   = (count_reg == CW'(CORE_TIMEOUT)) && !complete;
  assign carry     = (bus.i_core_result[30:23] != s8_reg);
  assign e_final   = e_base_reg + $signed({9'd0, carry});
  assign overflow  = (e_final >= 10'sd255);
  assign underflow = (e_final <= 10'sd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = special ? RESP : BUSY;
      BUSY:    if (complete || timeout) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.o_req_ready  = (state_reg == IDLE);
    bus.o_resp_valid = (state_reg == RESP);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_core_valid <= 1'b0;
      bus.o_core_a     <= 32'd0;
      bus.o_core_b     <= 32'd0;
      bus.o_result     <= 32'd0;
      bus.o_flags      <= 4'd0;
      count_reg        <= '0;
      e_base_reg       <= '0;
      s8_reg           <= 8'd0;
      sign_reg         <= 1'b0;
      core_valid_q     <= 1'b0;
    end else begin
      core_valid_q     <= bus.i_core_valid;
      bus.o_core_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            sign_reg <= sign_in;
            if (special) begin
              bus.o_result <= special_result;
              bus.o_flags  <= {invalid, 3'b000};
            end else begin
              bus.o_core_a     <= bus.i_a;
              bus.o_core_b     <= bus.i_b;
              bus.o_core_valid <= 1'b1;
              e_base_reg       <= $signed({2'b00, a_exp} + {2'b00, b_exp} - 10'd127);
              s8_reg           <= a_exp + b_exp;
              count_reg        <= '0;
            end
          end
        end
        BUSY: begin
          count_reg <= count_reg + CW'(1);
          if (complete) begin
            if (overflow) begin
              bus.o_result <= {sign_reg, 8'hFF, 23'd0};
              bus.o_flags  <= 4'b0100;
            end else if (underflow) begin
              bus.o_result <= {sign_reg, 31'd0};
              bus.o_flags  <= 4'b0010;
            end else begin
              bus.o_result <= {sign_reg, e_final[7:0], bus.i_core_result[22:0]};
              bus.o_flags  <= 4'b0000;
            end
          end else if (timeout) begin
            bus.o_result <= 32'h7FC0_0000;
            bus.o_flags  <= 4'b0001;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_issue.sv
// Bench for fp_mul_issue: table of operand pairs with a behavioural core model,
// scoreboard-checked responses, plus stale-valid timeout and mid-op reset sequences.
module tb_fp_mul_issue;
  localparam int TIMEOUT = 31;
  localparam int NV = 17;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
    bit          special;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  logic i_clk;
  logic i_rst_n;
  fp_mul_issue_if bus();

  fp_mul_issue #(.CORE_TIMEOUT(TIMEOUT)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[NV];
  int   core_lat = 1;
  bit   core_en = 1'b1;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Raw product as the iterative core presents it: exponent is the 8-bit
  // sum of operand exponents, bumped by one when the mantissa product carries.
  function automatic logic [31:0] core_model(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [7:0]  s;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    s = a[30:23] + b[30:23];
    if (p[47])
      return {a[31] ^ b[31], s + 8'd1, p[46:24]};
    return {a[31] ^ b[31], s, p[45:23]};
  endfunction

  initial begin
    forever begin
      @(negedge i_clk);
      if (bus.o_core_valid && core_en) begin
        bus.i_core_valid = 1'b0;
        repeat (core_lat) @(negedge i_clk);
        bus.i_core_result = core_model(bus.o_core_a, bus.o_core_b);
        bus.i_core_valid  = 1'b1;
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n && bus.o_resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got result %h flags %b, expected no response",
                 bus.o_result, bus.o_flags);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.o_result, e.res);
        check("flags", {28'd0, bus.o_flags}, {28'd0, e.flags});
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [3:0] flags,
                        input bit special, input int min_lat, input int max_lat,
                        input bit push);
    int   launches;
    int   cyc;
    bit   seen;
    exp_t e;
    check("ready_idle", {31'd0, bus.o_req_ready}, 32'd1);
    if (push) begin
      e.res   = res;
      e.flags = flags;
      sb.push_back(e);
    end
    bus.i_a = a;
    bus.i_b = b;
    bus.i_req_valid = 1'b1;
    @(negedge i_clk);
    bus.i_req_valid = 1'b0;
    if (!special) begin
      check("core_a", bus.o_core_a, a);
      check("core_b", bus.o_core_b, b);
    end
    launches = 0;
    seen = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      if (cyc > 1) @(negedge i_clk);
      if (bus.o_core_valid) launches++;
      if (bus.o_resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no response in 200 cycles, expected one");
    end else begin
      checks++;
      if (cyc < min_lat || cyc > max_lat) begin
        errors++;
        $display("FAIL latency: got %0d cycles, expected %0d..%0d", cyc, min_lat, max_lat);
      end
      check("ready_in_resp", {31'd0, bus.o_req_ready}, 32'd0);
    end
    check("launches", launches, special ? 32'd0 : 32'd1);
    @(negedge i_clk);
    check("resp_one_cycle", {31'd0, bus.o_resp_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},      {31'd0, bus.o_req_ready},  32'd1);
    check({tag, "_resp_valid"}, {31'd0, bus.o_resp_valid}, 32'd0);
    check({tag, "_core_valid"}, {31'd0, bus.o_core_valid}, 32'd0);
    check({tag, "_core_a"},     bus.o_core_a,              32'd0);
    check({tag, "_core_b"},     bus.o_core_b,              32'd0);
    check({tag, "_result"},     bus.o_result,              32'd0);
    check({tag, "_flags"},      {28'd0, bus.o_flags},      32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, 1'b0};
    vecs[1]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, 1'b0};
    vecs[2]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1'b1};
    vecs[3]  = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0100, 1'b0};
    vecs[4]  = '{32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 4'b0010, 1'b0};
    vecs[5]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1'b1};
    vecs[6]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 1'b1};
    vecs[7]  = '{32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 4'b0000, 1'b1};
    vecs[8]  = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 1'b1};
    vecs[9]  = '{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000, 1'b0};
    vecs[10] = '{32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 4'b0000, 1'b0};
    vecs[11] = '{32'h7F40_0000, 32'h3FC0_0000, 32'h7F80_0000, 4'b0100, 1'b0};
    vecs[12] = '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0010, 1'b0};
    vecs[13] = '{32'h00C0_0000, 32'h3F40_0000, 32'h0090_0000, 4'b0000, 1'b0};
    vecs[14] = '{32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, 4'b0000, 1'b1};
    vecs[15] = '{32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000, 1'b1};
    vecs[16] = '{32'h3F80_0000, 32'h0080_0000, 32'h0080_0000, 4'b0000, 1'b0};

    bus.i_req_valid   = 1'b0;
    bus.i_a           = 32'd0;
    bus.i_b           = 32'd0;
    bus.i_core_valid  = 1'b0;
    bus.i_core_result = 32'd0;
    i_rst_n = 1'b1;
    #1 i_rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < NV; i++) begin
      core_lat = 1 + (i % 4);
      if (vecs[i].special)
        run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags, 1'b1, 1, 1, 1'b1);
      else
        run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags, 1'b0,
               core_lat + 2, core_lat + 2, 1'b1);
      $display("vec %0d: a=%h b=%h result=%h flags=%b", i, vecs[i].a, vecs[i].b,
               bus.o_result, bus.o_flags);
    end

    // Core valid is still high from the last op and never pulses again.
    core_en = 1'b0;
    check("stale_valid_high", {31'd0, bus.i_core_valid}, 32'd1);
    run_op(32'h3F80_0000, 32'h4000_0000, 32'h7FC0_0000, 4'b0001, 1'b0,
           TIMEOUT + 1, TIMEOUT + 2, 1'b1);
    $display("timeout op: result=%h flags=%b", bus.o_result, bus.o_flags);
    core_en = 1'b1;
    core_lat = 2;
    run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, 1'b0, 4, 4, 1'b1);
    $display("post-timeout op: result=%h flags=%b", bus.o_result, bus.o_flags);

    // Abandon an op mid-BUSY with an asynchronous reset.
    core_en = 1'b0;
    bus.i_a = 32'h4000_0000;
    bus.i_b = 32'h4000_0000;
    bus.i_req_valid = 1'b1;
    @(negedge i_clk);
    bus.i_req_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    check("busy_before_reset", {31'd0, bus.o_req_ready}, 32'd0);
    #2;
    i_rst_n = 1'b0;
    bus.i_core_valid = 1'b0;
    #1 check_reset_outputs("midreset");
    $display("mid-busy reset: ready=%b result=%h", bus.o_req_ready, bus.o_result);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    core_en = 1'b1;
    @(negedge i_clk);
    core_lat = 3;
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, 1'b0, 5, 5, 1'b1);
    $display("post-reset op: result=%h flags=%b", bus.o_result, bus.o_flags);

    repeat (2) @(negedge i_clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
